// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory with a one-entry registered response (IF/ID boundary).
// Define IMEM_LOAD_EN to add the run-time program-load port; otherwise the array is a read-only image.
module inst_mem_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
`ifndef IMEM_LOAD_EN
  ,
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE = '0
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_fault
`ifdef IMEM_LOAD_EN
  ,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              ld_block;
  logic [IDX_W-1:0]  req_idx;
  logic              req_oor;
  logic              req_mis;
  logic [1:0]        req_fault;
  logic [DATA_W-1:0] rd_word;

  assign req_idx = req_addr[IDX_W+1:2];
  assign req_mis = |req_addr[1:0];

`ifdef IMEM_LOAD_EN
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [IDX_W-1:0]  ld_idx;
  logic              ld_oor;
  logic              ld_bad;

  assign ld_idx   = ld_addr[IDX_W+1:2];
  assign ld_bad   = (|ld_addr[1:0]) || ld_oor;
  assign ld_block = ld_valid;
  assign rd_word  = mem[req_idx];

  // The response register holds its own copy, so a load to the held word only affects later fetches.
  always_ff @(posedge clk) begin
    if (!rst && ld_valid && !ld_bad) begin
      mem[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= ld_valid && ld_bad;
    end
  end
`else
  assign ld_block = 1'b0;
  assign rd_word  = INIT_IMAGE[int'(req_idx)*DATA_W +: DATA_W];
`endif

  // Addresses above the array fault rather than aliasing onto low words.
  generate
    if (IDX_W + 2 < ADDR_W) begin : g_range
      assign req_oor = |req_addr[ADDR_W-1:IDX_W+2];
`ifdef IMEM_LOAD_EN
      assign ld_oor  = |ld_addr[ADDR_W-1:IDX_W+2];
`endif
    end else begin : g_no_range
      assign req_oor = 1'b0;
`ifdef IMEM_LOAD_EN
      assign ld_oor  = 1'b0;
`endif
    end
  endgenerate

  assign req_fault = req_mis ? 2'b01 : (req_oor ? 2'b10 : 2'b00);

  always_comb begin
    state_nxt = state;
    req_ready = !ld_block && ((state == ST_EMPTY) || rsp_ready);
    accept    = req_valid && req_ready;
    if (accept) begin
      state_nxt = ST_FULL;
    end else if ((state == ST_FULL) && rsp_ready) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      rsp_inst  <= '0;
      rsp_addr  <= '0;
      rsp_fault <= 2'b00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_inst  <= (req_fault == 2'b00) ? rd_word : '0;
        rsp_addr  <= req_addr;
        rsp_fault <= req_fault;
      end
    end
  end

  assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed bench for inst_mem_sync: handshake, back-pressure, faults, reset, and load port when IMEM_LOAD_EN is set.
module tb_inst_mem_sync;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;

  function automatic logic [DEPTH*DATA_W-1:0] build_image();
    logic [DEPTH*DATA_W-1:0] img;
    img = '0;
    for (int i = 0; i < DEPTH; i++) img[i*DATA_W +: DATA_W] = 32'hC0DE_0000 | 32'(i);
    return img;
  endfunction

  localparam logic [DEPTH*DATA_W-1:0] IMAGE = build_image();

  function automatic logic [31:0] exp_word(input int i);
`ifdef IMEM_LOAD_EN
    return 32'h0;
`else
    return 32'hC0DE_0000 | 32'(i);
`endif
  endfunction

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_inst;
  logic [ADDR_W-1:0] rsp_addr;
  logic [1:0]        rsp_fault;
`ifdef IMEM_LOAD_EN
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_mem_sync #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
`ifndef IMEM_LOAD_EN
    ,
    .INIT_IMAGE(IMAGE)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_inst (rsp_inst),
    .rsp_addr (rsp_addr),
    .rsp_fault(rsp_fault)
`ifdef IMEM_LOAD_EN
    ,
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_err   (ld_err)
`endif
  );

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic vld, input logic [31:0] inst,
                         input logic [31:0] addr, input logic [1:0] flt);
    chk_val({tag, "_valid"}, 64'(rsp_valid), 64'(vld));
    chk_val({tag, "_inst"},  64'(rsp_inst),  64'(inst));
    chk_val({tag, "_addr"},  64'(rsp_addr),  64'(addr));
    chk_val({tag, "_fault"}, 64'(rsp_fault), 64'(flt));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
`ifdef IMEM_LOAD_EN
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
`endif
    tick();
    tick();
    chk_rsp("reset", 1'b0, 32'h0, 32'h0, 2'b00);
`ifdef IMEM_LOAD_EN
    chk_val("reset_ld_err", 64'(ld_err), 64'h0);
`endif

    // back-to-back fetches 0x0, 0x4, 0x8
    rst = 1'b0; req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    #1 chk_val("b2b_ready0", 64'(req_ready), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rsp($sformatf("b2b%0d", i), 1'b1, exp_word(i), 32'(i*4), 2'b00);
      req_addr = 32'(i*4 + 4);
      #1 chk_val($sformatf("b2b_ready%0d", i + 1), 64'(req_ready), 64'h1);
    end
    req_valid = 1'b0;
    tick();
    chk_val("b2b_drain", 64'(rsp_valid), 64'h0);

    // back-pressure: 0x4 held while 0x8 waits
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
    tick();
    req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_rsp($sformatf("stall%0d", i), 1'b1, exp_word(1), 32'h4, 2'b00);
      chk_val($sformatf("stall_ready%0d", i), 64'(req_ready), 64'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk_val("stall_release_ready", 64'(req_ready), 64'h1);
    tick();
    chk_rsp("stall_next", 1'b1, exp_word(2), 32'h8, 2'b00);
    req_valid = 1'b0;
    tick();

    // fault classification and range boundary
    req_valid = 1'b1; req_addr = 32'h6;
    tick();
    chk_rsp("mis", 1'b1, 32'h0, 32'h6, 2'b01);
    req_addr = 32'h400;
    tick();
    chk_rsp("oor", 1'b1, 32'h0, 32'h400, 2'b10);
    req_addr = 32'h402;
    tick();
    chk_rsp("mis_prec", 1'b1, 32'h0, 32'h402, 2'b01);
    req_addr = 32'h8000_0000;
    tick();
    chk_rsp("no_alias", 1'b1, 32'h0, 32'h8000_0000, 2'b10);
    req_addr = 32'h3FC;
    tick();
    chk_rsp("last", 1'b1, exp_word(255), 32'h3FC, 2'b00);
    req_valid = 1'b0;
    tick();

    // reset while full and stalled
    req_valid = 1'b1; req_addr = 32'h8; rsp_ready = 1'b0;
    tick();
    chk_val("pre_rst_valid", 64'(rsp_valid), 64'h1);
    req_valid = 1'b0; rst = 1'b1;
`ifdef IMEM_LOAD_EN
    ld_valid = 1'b1; ld_addr = 32'h20; ld_data = 32'hDEAD_BEEF;
`endif
    tick();
    chk_rsp("mid_rst", 1'b0, 32'h0, 32'h0, 2'b00);
    rst = 1'b0; req_valid = 1'b1; req_addr = 32'h8; rsp_ready = 1'b1;
`ifdef IMEM_LOAD_EN
    ld_valid = 1'b0;
`endif
    #1 chk_val("post_rst_ready", 64'(req_ready), 64'h1);
    tick();
    chk_rsp("post_rst", 1'b1, exp_word(2), 32'h8, 2'b00);
    req_addr = 32'h20;
    tick();
    chk_rsp("rst_ld_blocked", 1'b1, exp_word(8), 32'h20, 2'b00);
    req_valid = 1'b0;
    tick();

`ifdef IMEM_LOAD_EN
    // load and request together: load wins, request goes next cycle
    ld_valid = 1'b1; ld_addr = 32'h10; ld_data = 32'h2002_000F;
    req_valid = 1'b1; req_addr = 32'h10;
    #1 chk_val("ld_block_ready", 64'(req_ready), 64'h0);
    tick();
    chk_val("ld_ok_err", 64'(ld_err), 64'h0);
    chk_val("ld_block_valid", 64'(rsp_valid), 64'h0);
    ld_valid = 1'b0;
    #1 chk_val("ld_after_ready", 64'(req_ready), 64'h1);
    tick();
    chk_rsp("ld_fetch", 1'b1, 32'h2002_000F, 32'h10, 2'b00);
    req_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h12; ld_data = 32'h1234_5678;
    tick();
    chk_val("ld_mis_err", 64'(ld_err), 64'h1);
    ld_valid = 1'b0;
    tick();
    chk_val("ld_err_pulse", 64'(ld_err), 64'h0);
    req_valid = 1'b1; req_addr = 32'h10;
    tick();
    chk_rsp("ld_mis_nowrite", 1'b1, 32'h2002_000F, 32'h10, 2'b00);
    req_valid = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
